pong_input_port: RTL and testbench

- Carries game input in the reverse direction of the processor-to-VGA ball path: from board and VGA hardware into the processor.
- Synchronizes and debounces the four paddle buttons (moveleft, moveright, moveup, movedown).
- Counts VGA frames from VGA_VS.
- Presents button levels, sticky press events and the frame count as a memory-mapped read-only register window on the processor's 12-bit data-address space, beside dmem.

---
 rtl/pong_input_port_if.sv | 11 +
 rtl/pong_input_port.sv | 114 +++++++++++
 tb/tb_pong_input_port.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pong_input_port_if.sv
// Processor load port into the game-input register window.
// The processor drives the strobe and address, and the port returns a registered hit flag and data.
interface pong_input_port_if;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        rd_hit;
    logic [31:0] rd_data;

    modport master (output rd_en, rd_addr, input  rd_hit, rd_data);
    modport slave  (input  rd_en, rd_addr, output rd_hit, rd_data);
endinterface

// File: rtl/pong_input_port.sv
// Game input port: synchronizes and debounces the paddle buttons and counts VGA frames.
// It exposes the results as a three-word read-only register window next to dmem.
module pong_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter logic [11:0] BASE_ADDR       = 12'hFF0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       btn_raw,
    input  logic             vga_vs,
    pong_input_port_if.slave bus,
    output logic [3:0]       btn_level
);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_EVENTS = 2'd1,
        REG_FRAME  = 2'd2
    } reg_sel_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_meta_q, btn_sync_q;
    logic             vs_meta_q, vs_sync_q, vs_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q, level_d;
    logic [3:0]       press_q, press_d;
    logic             frame_flag_q, frame_flag_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic             rd_hit_q, rd_hit_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [11:0]      offset;
    logic             frame_edge;

    assign offset     = bus.rd_addr - BASE_ADDR;
    assign frame_edge = vs_prev_q & ~vs_sync_q;

    // NOTE: every variable gets a default at the top of the block, so no path leaves it unassigned and infers a latch.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (btn_sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) level_d[i] = btn_sync_q[i];
                else                      cnt_d[i]   = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_hit_d     = bus.rd_en && (offset < 12'd3);
        rd_data_d    = '0;
        press_d      = press_q;
        frame_flag_d = frame_flag_q;
        if (rd_hit_d) begin
            unique case (reg_sel_e'(offset[1:0]))
                REG_STATUS: rd_data_d = {frame_cnt_q[15:0], 7'd0, frame_flag_q, press_q, level_q};
                REG_EVENTS: begin
                    rd_data_d = {28'd0, press_q};
                    press_d   = '0;
                end
                REG_FRAME: begin
                    rd_data_d    = frame_cnt_q;
                    frame_flag_d = 1'b0;
                end
                default: rd_data_d = '0;
            endcase
        end
        // A new event on the clearing edge wins over the clear.
        press_d      = press_d | (level_d & ~level_q);
        frame_flag_d = frame_flag_d | frame_edge;
        frame_cnt_d  = frame_cnt_q + {31'd0, frame_edge};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            btn_meta_q   <= '0;
            btn_sync_q   <= '0;
            vs_meta_q    <= 1'b0;
            vs_sync_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            // NOTE: the four-entry counter array is plain flops, so it is reset like any other register.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            level_q      <= '0;
            press_q      <= '0;
            frame_flag_q <= 1'b0;
            frame_cnt_q  <= '0;
            rd_hit_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            btn_meta_q   <= btn_raw;
            btn_sync_q   <= btn_meta_q;
            vs_meta_q    <= vga_vs;
            vs_sync_q    <= vs_meta_q;
            vs_prev_q    <= vs_sync_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            level_q      <= level_d;
            press_q      <= press_d;
            frame_flag_q <= frame_flag_d;
            frame_cnt_q  <= frame_cnt_d;
            rd_hit_q     <= rd_hit_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign btn_level   = level_q;
    assign bus.rd_hit  = rd_hit_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_pong_input_port.sv
// Directed bench for pong_input_port with a short debounce window.
// Expected reads are queued when issued and compared when the registered response appears.
`timescale 1ns/1ps
module tb_pong_input_port;

    localparam logic [11:0] BASE = 12'hFF0;

    logic       clock;
    logic       resetn;
    logic [3:0] btn_raw;
    logic       vga_vs;
    logic [3:0] btn_level;

    pong_input_port_if bus ();

    pong_input_port #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (18),
        .BASE_ADDR      (BASE)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .btn_raw  (btn_raw),
        .vga_vs   (vga_vs),
        .bus      (bus.slave),
        .btn_level(btn_level)
    );

    typedef struct {
        string       tag;
        logic        hit;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Issued on a falling edge, sampled on the next rising edge, checked on the following falling edge.
    task automatic rd(input string tag, input logic [11:0] addr, input logic hit, input logic [31:0] data);
        exp_t e;
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        e.tag  = tag;
        e.hit  = hit;
        e.data = data;
        sb_q.push_back(e);
        @(negedge clock);
        bus.rd_en = 1'b0;
        e = sb_q.pop_front();
        check({e.tag, "_hit"}, {31'd0, bus.rd_hit}, {31'd0, e.hit});
        check(e.tag, bus.rd_data, e.data);
    endtask

    task automatic vs_pulse;
        vga_vs = 1'b0;
        tick(3);
        vga_vs = 1'b1;
        tick(3);
    endtask

    initial begin
        resetn      = 1'b1;
        btn_raw     = '0;
        vga_vs      = 1'b1;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        #1 resetn = 1'b0;
        tick(2);
        check("reset_level", {28'd0, btn_level}, 32'd0);
        check("reset_hit",   {31'd0, bus.rd_hit}, 32'd0);
        check("reset_data",  bus.rd_data, 32'd0);
        resetn = 1'b1;
        tick(3);
        rd("status_after_reset", BASE, 1'b1, 32'h0);

        // Clean press of moveup: level rises on the sixth edge after the raw change.
        btn_raw[2] = 1'b1;
        tick(5);
        check("up_level_edge5", {28'd0, btn_level}, 32'h0);
        tick(1);
        check("up_level_edge6", {28'd0, btn_level}, 32'h4);
        rd("status_up", BASE, 1'b1, 32'h44);
        btn_raw[2] = 1'b0;
        tick(8);
        check("up_released", {28'd0, btn_level}, 32'h0);
        rd("events_up", BASE + 12'd1, 1'b1, 32'h4);
        rd("status_cleared", BASE, 1'b1, 32'h0);

        // Three-cycle glitch on moveleft is one cycle short of acceptance.
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        tick(8);
        check("bounce_level", {28'd0, btn_level}, 32'h0);
        rd("bounce_status", BASE, 1'b1, 32'h0);

        // Read-to-clear on moveright, back-to-back reads.
        btn_raw[1] = 1'b1;
        tick(6);
        check("right_level", {28'd0, btn_level}, 32'h2);
        rd("events_right", BASE + 12'd1, 1'b1, 32'h2);
        rd("events_right_clr", BASE + 12'd1, 1'b1, 32'h0);
        btn_raw[1] = 1'b0;
        tick(8);
        btn_raw[1] = 1'b1;
        tick(6);
        btn_raw[1] = 1'b0;
        tick(8);
        // Second press lands on the same edge as the clearing read: the flag survives.
        btn_raw[1] = 1'b1;
        tick(5);
        rd("events_collide", BASE + 12'd1, 1'b1, 32'h2);
        rd("events_survived", BASE + 12'd1, 1'b1, 32'h2);
        rd("events_final", BASE + 12'd1, 1'b1, 32'h0);
        btn_raw[1] = 1'b0;
        tick(8);

        // Frame counting.
        repeat (5) vs_pulse();
        tick(3);
        rd("status_frames", BASE, 1'b1, 32'h0005_0100);
        rd("frame_5", BASE + 12'd2, 1'b1, 32'd5);
        rd("status_flag_clr", BASE, 1'b1, 32'h0005_0000);
        dut.frame_cnt_q = 32'hFFFF_FFFF;
        vs_pulse();
        tick(2);
        rd("frame_wrap", BASE + 12'd2, 1'b1, 32'd0);

        // Address decode just outside the window has no side effects.
        btn_raw[0] = 1'b1;
        tick(6);
        check("left_level", {28'd0, btn_level}, 32'h1);
        rd("below_window", BASE - 12'd1, 1'b0, 32'h0);
        rd("above_window", BASE + 12'd3, 1'b0, 32'h0);
        rd("events_left", BASE + 12'd1, 1'b1, 32'h1);
        btn_raw[0] = 1'b0;
        tick(8);

        // Asynchronous reset while a read response and a button level are live.
        btn_raw[3] = 1'b1;
        tick(6);
        check("down_level", {28'd0, btn_level}, 32'h8);
        bus.rd_en   = 1'b1;
        bus.rd_addr = BASE;
        @(posedge clock);
        #2;
        check("live_hit",  {31'd0, bus.rd_hit}, 32'd1);
        check("live_data", bus.rd_data, 32'h88);
        resetn = 1'b0;
        #1;
        check("async_level", {28'd0, btn_level}, 32'h0);
        check("async_hit",   {31'd0, bus.rd_hit}, 32'd0);
        check("async_data",  bus.rd_data, 32'h0);
        @(negedge clock);
        btn_raw   = '0;
        bus.rd_en = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(3);
        rd("status_post_reset", BASE, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
